// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-cycle memory with WAIT_CYCLES hold time.
// Round-robin arbitration when ARB_ROUND_ROBIN_EN is defined, fixed data-first priority otherwise.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic [3:0] count;
  logic       owner_d;
  logic       pick_d;
  logic       gnt_vld;
  logic       gnt_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  assign pick_d = d_req && (!i_req || !last_d);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_d   = pick_d;
    case (state)
      IDLE: gnt_vld = i_req | d_req;
      RESP: begin
        gnt_d   = !owner_d;
        gnt_vld = owner_d ? i_req : d_req;
`ifndef ARB_ROUND_ROBIN_EN
        // A data port that keeps requesting sends us back through IDLE, where it wins again.
        if (owner_d && d_req) gnt_vld = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      owner_d  <= 1'b0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rdata  <= 32'd0;
      d_rdata  <= 32'd0;
      mem_ren  <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= 32'd0;
      mem_din  <= 32'd0;
      busy     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d   <= 1'b1;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        ACCESS: begin
          if (count == 4'd0) begin
            state    <= RESP;
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= 32'd0;
            mem_din  <= 32'd0;
            if (owner_d) begin
              d_ack <= 1'b1;
              if (mem_ren) d_rdata <= mem_dout;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= mem_dout;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          // IDLE and RESP share the grant path; the mem bus registers double as the request latch.
          if (gnt_vld) begin
            state    <= ACCESS;
            busy     <= 1'b1;
            count    <= 4'(WAIT_CYCLES);
            owner_d  <= gnt_d;
            mem_addr <= gnt_d ? d_addr : i_addr;
            mem_din  <= (gnt_d && d_we) ? d_wdata : 32'd0;
            mem_wen  <= gnt_d && d_we;
            mem_ren  <= !(gnt_d && d_we);
`ifdef ARB_ROUND_ROBIN_EN
            last_d   <= gnt_d;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected accesses, a negedge monitor checks them.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, mem_ren, mem_wen, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;

  logic        z_i_req;
  logic [31:0] z_i_addr;
  logic        z_i_ack, z_d_ack, z_mem_ren, z_mem_wen, z_busy;
  logic [31:0] z_i_rdata, z_d_rdata, z_mem_addr, z_mem_din, z_mem_dout;

  localparam int WC = 1;

  assign mem_dout   = {16'hCAFE, mem_addr[15:0]};
  assign z_mem_dout = {16'hCAFE, z_mem_addr[15:0]};

  mem_port_arbiter #(.WAIT_CYCLES(WC)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  mem_port_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_ack(z_i_ack), .i_rdata(z_i_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .mem_ren(z_mem_ren), .mem_wen(z_mem_wen), .mem_addr(z_mem_addr), .mem_din(z_mem_din),
    .mem_dout(z_mem_dout), .busy(z_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mi = 32'd0;
  logic [31:0] md = 32'd0;
  int          checks = 0;
  int          failures = 0;
  int          en_cyc = 0;
  int          acks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input bit is_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int ack_cyc);
    exp_t e;
    e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.ack_cyc = ack_cyc;
    if (!we) begin
      e.rdata = {16'hCAFE, addr[15:0]};
      if (is_d) md = e.rdata; else mi = e.rdata;
    end else begin
      e.rdata = is_d ? md : mi;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: checks every memory access cycle and every ack against the head of the queue.
  always @(negedge clock) begin
    if (!reset) begin
      en_cyc = 0;
    end else begin
      if (mem_ren || mem_wen) begin
        en_cyc++;
        chk("ren_wen_exclusive", {31'd0, mem_ren & mem_wen}, 32'd0);
        chk("busy_in_access", {31'd0, busy}, 32'd1);
        chk("access_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          chk("mem_addr", mem_addr, exp_q[0].addr);
          chk("mem_wen", {31'd0, mem_wen}, {31'd0, exp_q[0].we});
          if (exp_q[0].we) chk("mem_din", mem_din, exp_q[0].wdata);
        end
      end
      if (i_ack || d_ack) begin
        exp_t e;
        acks++;
        chk("single_ack", {31'd0, i_ack & d_ack}, 32'd0);
        chk("resp_mem_idle", {mem_addr[31:2], mem_ren, mem_wen}, 32'd0);
        chk("ack_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ack_port", {31'd0, d_ack}, {31'd0, e.is_d});
          chk("access_len", en_cyc, WC + 1);
          chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
          if (e.ack_cyc >= 0) chk("ack_cycle", cyc, e.ack_cyc);
        end
        en_cyc = 0;
      end
    end
  end

  task automatic serve(input int n, input bit hold);
    int got = 0;
    int t = 0;
    while (got < n && t < 80) begin
      @(negedge clock);
      t++;
      if (i_ack || d_ack) got++;
      if (!hold) begin
        if (i_ack) i_req = 1'b0;
        if (d_ack) d_req = 1'b0;
      end else if (got == n) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    chk("serve_acks", got, n);
    repeat (2) @(negedge clock);
  endtask

  int c;
  int a0;
  int rc;
  int ack_at;

  initial begin
    reset = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    z_i_req = 0; z_i_addr = 0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_en", {30'd0, mem_ren, mem_wen}, 32'd0);
    chk("rst_ack", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Fetch read at 0x10
    c = cyc; push(0, 0, 32'h10, 32'h0, c + 3);
    i_addr = 32'h10; i_req = 1;
    serve(1, 0);

    // Data read, request dropped mid-access
    c = cyc; push(1, 0, 32'h24, 32'h0, c + 3);
    d_addr = 32'h24; d_we = 0; d_req = 1;
    @(negedge clock);
    d_req = 0;
    serve(1, 0);

    // Data write; request fields change after the grant
    c = cyc; push(1, 1, 32'h20, 32'h12345678, c + 3);
    d_addr = 32'h20; d_wdata = 32'h12345678; d_we = 1; d_req = 1;
    @(negedge clock);
    d_addr = 32'h30; d_wdata = 32'hDEADBEEF; d_we = 0;
    serve(1, 0);

    // Both ports held continuously
    c = cyc;
`ifdef ARB_ROUND_ROBIN_EN
    push(0, 0, 32'h40, 32'h0, c + 3);
    push(1, 0, 32'h50, 32'h0, c + 6);
    push(0, 0, 32'h40, 32'h0, c + 9);
    push(1, 0, 32'h50, 32'h0, c + 12);
`else
    push(1, 0, 32'h50, 32'h0, c + 3);
    push(1, 0, 32'h50, 32'h0, c + 7);
    push(1, 0, 32'h50, 32'h0, c + 11);
    push(1, 0, 32'h50, 32'h0, c + 15);
`endif
    i_addr = 32'h40; d_addr = 32'h50; d_we = 0;
    i_req = 1; d_req = 1;
    serve(4, 1);

    // Reset in the second access cycle of a write
    push(1, 1, 32'h60, 32'hA5A5A5A5, -1);
    d_addr = 32'h60; d_wdata = 32'hA5A5A5A5; d_we = 1; d_req = 1;
    repeat (2) @(negedge clock);
    chk("pre_reset_wen", {31'd0, mem_wen}, 32'd1);
    #1;
    reset = 1'b0;
    d_req = 0;
    #1;
    chk("async_rst_wen", {31'd0, mem_wen}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_addr", mem_addr, 32'd0);
    chk("async_rst_i_rdata", i_rdata, 32'd0);
    chk("async_rst_d_rdata", d_rdata, 32'd0);
    exp_q.delete();
    mi = 32'd0; md = 32'd0;
    a0 = acks;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("no_ack_after_reset", acks - a0, 0);

    // Simultaneous single requests right after reset
    c = cyc;
`ifdef ARB_ROUND_ROBIN_EN
    push(0, 0, 32'h70, 32'h0, c + 3);
    push(1, 0, 32'h74, 32'h0, c + 6);
`else
    push(1, 0, 32'h74, 32'h0, c + 3);
    push(0, 0, 32'h70, 32'h0, c + 6);
`endif
    i_addr = 32'h70; d_addr = 32'h74; d_we = 0;
    i_req = 1; d_req = 1;
    serve(2, 0);
    chk("queue_drained", exp_q.size(), 0);

    // Zero wait-cycle instance
    c = cyc; rc = 0; ack_at = -1;
    z_i_addr = 32'h80; z_i_req = 1;
    repeat (6) begin
      @(negedge clock);
      if (z_mem_ren) rc++;
      if (z_i_ack) begin
        ack_at = cyc;
        z_i_req = 0;
      end
    end
    chk("w0_ren_len", rc, 1);
    chk("w0_ack_cycle", ack_at, c + 2);
    chk("w0_rdata", z_i_rdata, 32'hCAFE0080);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra cycles each access holds the memory port (legal 0..15).
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_req  input  1  instruction-fetch read request, held until i_ack.
REQ-005 SHALL have port i_addr  input  32  instruction word address.
REQ-006 SHALL have port i_ack  output  1  one-cycle completion pulse, fetch port.
REQ-007 SHALL have port i_rdata  output  32  fetched word, valid with i_ack, held until next i_ack.
REQ-008 SHALL have port d_req  input  1  data request, held until d_ack.
REQ-009 SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port d_addr  input  32  data word address.
REQ-011 SHALL have port d_wdata  input  32  write data.
REQ-012 SHALL have port d_ack  output  1  one-cycle completion pulse, data port.
REQ-013 SHALL have port d_rdata  output  32  read word, valid with d_ack on reads, held until next d_ack.
REQ-014 SHALL have ports mem_ren, mem_wen  output  1 each  memory read/write enables.
REQ-015 SHALL have ports mem_addr, mem_din  output  32 each  memory address and write data.
REQ-016 SHALL have port mem_dout  input  32  memory combinational read data.
REQ-017 SHALL have port busy  output  1  high while state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, ACCESS, RESP; all outputs registered.
REQ-019 IDLE: on rising edge with any req high SHALL arbitrate, latch owner, address, we, wdata, load counter with WAIT_CYCLES, go to ACCESS.
REQ-020 ACCESS: SHALL drive mem_addr/mem_din from latched values, mem_ren = owner read, mem_wen = owner write, stable for WAIT_CYCLES+1 cycles; counter decrements each cycle; at count 0 SHALL go to RESP.
REQ-021 Last ACCESS edge SHALL capture mem_dout into owner's rdata register on reads; writes SHALL leave rdata unchanged.
REQ-022 RESP: SHALL pulse owner's ack for exactly one cycle, mem_ren = mem_wen = 0, mem_addr = mem_din = 0.
REQ-023 RESP SHALL arbitrate excluding the port being acked; if the other port requests, go directly to ACCESS, else IDLE.
REQ-024 Latency: req sampled in IDLE -> ack asserted WAIT_CYCLES+2 cycles later.
REQ-025 mem_ren and mem_wen SHALL never be high together; both 0 outside ACCESS.
REQ-026 Requester changing addr/we/wdata after grant SHALL not affect the access in flight.
REQ-027 Requester dropping req before ack SHALL not abort the access; ack still issued.
REQ-028 Only one ack SHALL be high in any cycle.

Reset
REQ-029 reset low SHALL immediately force state IDLE, counter 0, all outputs 0, i_rdata = d_rdata = 0, last-grant = data.
REQ-030 Reset during ACCESS SHALL abandon the access with no ack after reset release.

Configuration
REQ-031 With ARB_ROUND_ROBIN_EN defined, on simultaneous requests SHALL grant the port not granted last (fetch first after reset); last-grant updates on every grant.
REQ-032 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority: data port always wins simultaneous requests.

Verification
REQ-033 WAIT_CYCLES=1, i_req with i_addr=0x10, mem_dout=0xCAFE0010 -> mem_ren high 2 cycles, i_ack pulse 3 cycles after sampling, i_rdata=0xCAFE0010.
REQ-034 d_req, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> mem_wen high 2 cycles with mem_addr=0x20, mem_din=0x12345678, d_ack pulse, d_rdata unchanged, mem_ren stays 0.
REQ-035 i_req and d_req held continuously, round-robin defined -> grants alternate I,D,I,D with no IDLE cycle between; undefined -> D served repeatedly, i_ack never while d_req held.
REQ-036 WAIT_CYCLES=0 read -> mem_ren high 1 cycle, ack 2 cycles after sampling.
REQ-037 reset low in second ACCESS cycle of a write -> mem_wen falls asynchronously, busy=0, no d_ack after release.
REQ-038 Change d_addr 0x20->0x30 mid-ACCESS -> mem_addr remains 0x20 until RESP.
